// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT sample RAM readers.
// Holds the read-master FSM state encoding and the address bit-reversal function.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } fft_rd_state_e;

    localparam int FIFO_DEPTH = 3;

    // Reverses the low 'width' bits of value; bits at or above width come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                r[i] = value[width-1-i];
            end else begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_out_fifo.sv
// Three-entry synchronous FIFO with a registered head word.
// Entries shift toward slot 0, so the visible head is always a flop.
module fft_out_fifo
    import fft_pkg::*;
#(
    parameter int FW = 8
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [FW-1:0] i_din,
    input  logic          i_pop,
    output logic [FW-1:0] o_head,
    output logic          o_valid,
    output logic [1:0]    o_count
);

    logic [FW-1:0] r_ent     [FIFO_DEPTH];
    logic [FW-1:0] w_ent_nxt [FIFO_DEPTH];
    logic [1:0]    r_count;
    logic [1:0]    w_count_nxt;
    logic [1:0]    w_pos;
    logic          r_valid;
    logic          w_pop;

    assign w_pop = i_pop && r_valid;

    // Shift on pop, then drop the pushed word into the first free slot.
    always_comb begin
        w_ent_nxt   = r_ent;
        w_count_nxt = r_count;
        w_pos       = r_count;
        if (w_pop) begin
            w_ent_nxt[0] = r_ent[1];
            w_ent_nxt[1] = r_ent[2];
            w_count_nxt  = r_count - 2'd1;
            w_pos        = r_count - 2'd1;
        end else begin
            w_pos        = r_count;
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (i_push && (w_pos == 2'(i))) begin
                w_ent_nxt[i] = i_din;
            end else begin
                w_ent_nxt[i] = w_ent_nxt[i];
            end
        end
        if (i_push && (w_pos != 2'd3)) begin
            w_count_nxt = w_count_nxt + 2'd1;
        end else begin
            w_count_nxt = w_count_nxt;
        end
    end

    // Storage, occupancy and registered valid flag.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_ent[i] <= {FW{1'b0}};
            end
            r_count <= 2'd0;
            r_valid <= 1'b0;
        end else begin
            r_ent   <= w_ent_nxt;
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != 2'd0);
        end
    end

    assign o_head  = r_ent[0];
    assign o_valid = r_valid;
    assign o_count = r_count;

endmodule

// File: rtl/fft_bitrev_reader.sv
// Read-side master for the FFT sample RAM: walks all DEPTH words in bit-reversed or
// natural order and streams them out on a valid/ready bus, absorbing backpressure.
module fft_bitrev_reader
    import fft_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 256,
    parameter int BITREV = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   ram_addr,
    output logic                       ram_we,
    output logic [WIDTH-1:0]           ram_din,
    input  logic [WIDTH-1:0]           ram_dout,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [WIDTH-1:0]           m_data,
    output logic [$clog2(DEPTH)-1:0]   m_index,
    output logic                       m_last
);

    localparam int              AW        = $clog2(DEPTH);
    localparam int              FW        = WIDTH + AW + 1;
    localparam logic [AW:0]     LAST_IDX  = (AW+1)'(DEPTH - 1);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);

    fft_rd_state_e r_state, w_state_nxt;
    logic [AW:0]   r_idx;
    logic [AW-1:0] r_rd_idx;
    logic [AW-1:0] r_ram_addr;
    logic [AW-1:0] w_addr_now;
    logic [31:0]   w_rev;
    logic          r_rd_pend;
    logic          r_busy;
    logic          r_done;
    logic          w_issue;
    logic          w_done_nxt;
    logic          w_credit_ok;
    logic [1:0]    w_fifo_count;
    logic [FW-1:0] w_head;
    logic [FW-1:0] w_push_word;
    logic          w_fifo_valid;
    logic          w_pop;

    assign w_rev       = bitrev(32'(r_idx[AW-1:0]), AW);
    assign w_addr_now  = (BITREV != 0) ? AW'(w_rev) : r_idx[AW-1:0];
    // Words in the FIFO plus the one in flight from the RAM never exceed the FIFO size.
    assign w_credit_ok = ({1'b0, w_fifo_count} + {2'b00, r_rd_pend}) < 3'd3;
    assign w_pop       = w_fifo_valid && m_ready;
    assign w_push_word = {ram_dout, r_rd_idx, (r_rd_idx == LAST_ADDR)};

    // Next-state, issue and done decode.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = READ;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            READ: begin
                if (w_credit_ok) begin
                    w_issue = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = DRAIN;
                    end else begin
                        w_state_nxt = READ;
                    end
                end else begin
                    w_state_nxt = READ;
                end
            end
            DRAIN: begin
                if (!r_rd_pend && (w_fifo_count == 2'd1) && w_pop && w_head[0]) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM state, index counter, read pipeline tag and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= {(AW+1){1'b0}};
            r_rd_idx   <= {AW{1'b0}};
            r_ram_addr <= {AW{1'b0}};
            r_rd_pend  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_pend <= w_issue;
            r_busy    <= (w_state_nxt != IDLE);
            r_done    <= w_done_nxt;
            if ((r_state == IDLE) && start) begin
                r_idx <= {(AW+1){1'b0}};
            end else if (w_issue) begin
                r_idx <= r_idx + {{AW{1'b0}}, 1'b1};
            end else begin
                r_idx <= r_idx;
            end
            if (w_issue) begin
                r_rd_idx   <= r_idx[AW-1:0];
                r_ram_addr <= w_addr_now;
            end else begin
                r_rd_idx   <= r_rd_idx;
                r_ram_addr <= r_ram_addr;
            end
        end
    end

    fft_out_fifo #(
        .FW (FW)
    ) u_fifo (
        .clk     (clk),
        .i_rst   (rst),
        .i_push  (r_rd_pend),
        .i_din   (w_push_word),
        .i_pop   (m_ready),
        .o_head  (w_head),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

    // The address goes out in the issuing cycle so the RAM samples it at that edge.
    assign ram_addr = w_issue ? w_addr_now : r_ram_addr;
    assign ram_we   = 1'b0;
    assign ram_din  = {WIDTH{1'b0}};
    assign busy     = r_busy;
    assign done     = r_done;
    assign m_valid  = w_fifo_valid;
    assign m_data   = w_head[FW-1 -: WIDTH];
    assign m_index  = w_head[AW:1];
    assign m_last   = w_head[0];

endmodule

// File: tb/tb_fft_bitrev_reader.sv
// Bench for fft_bitrev_reader: an 8-word bit-reversed reader and a 16-word natural-order
// reader, each fed by a registered-read RAM model, checked beat by beat against a scoreboard.
module tb_fft_bitrev_reader;

    localparam int W = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    logic         a_start = 1'b0, a_ready = 1'b1;
    logic         a_busy, a_done, a_we, a_valid, a_last;
    logic [2:0]   a_addr, a_index;
    logic [W-1:0] a_din, a_data;
    logic [W-1:0] a_dout = '0;

    logic         b_start = 1'b0, b_ready = 1'b1;
    logic         b_busy, b_done, b_we, b_valid, b_last;
    logic [3:0]   b_addr, b_index;
    logic [W-1:0] b_din, b_data;
    logic [W-1:0] b_dout = '0;

    logic [W-1:0] mem_a [8];
    logic [W-1:0] mem_b [16];

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0]   idx;
        logic [W-1:0] data;
        logic         last;
    } beat_t;
    beat_t sb_q[$];

    int           sel = 0;
    logic         s_valid, s_busy, s_done, s_last;
    logic [3:0]   s_index, s_addr;
    logic [W-1:0] s_data;

    fft_bitrev_reader #(.WIDTH(W), .DEPTH(8), .BITREV(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
        .ram_addr(a_addr), .ram_we(a_we), .ram_din(a_din), .ram_dout(a_dout),
        .m_valid(a_valid), .m_ready(a_ready), .m_data(a_data), .m_index(a_index), .m_last(a_last)
    );

    fft_bitrev_reader #(.WIDTH(W), .DEPTH(16), .BITREV(0)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .ram_addr(b_addr), .ram_we(b_we), .ram_din(b_din), .ram_dout(b_dout),
        .m_valid(b_valid), .m_ready(b_ready), .m_data(b_data), .m_index(b_index), .m_last(b_last)
    );

    // Registered-read RAM models.
    always @(posedge clk) begin
        a_dout <= mem_a[a_addr];
        b_dout <= mem_b[b_addr];
    end

    always_comb begin
        if (sel == 1) begin
            s_valid = b_valid; s_busy = b_busy; s_done = b_done; s_last = b_last;
            s_index = b_index; s_addr = b_addr; s_data = b_data;
        end else begin
            s_valid = a_valid; s_busy = a_busy; s_done = a_done; s_last = a_last;
            s_index = {1'b0, a_index}; s_addr = {1'b0, a_addr}; s_data = a_data;
        end
    end

    function automatic int brev3(input int v);
        return ((v & 1) << 2) | (v & 2) | ((v >> 2) & 1);
    endfunction

    task automatic drive_start(input logic v);
        if (sel == 1) b_start = v; else a_start = v;
    endtask

    task automatic drive_ready(input logic v);
        if (sel == 1) b_ready = v; else a_ready = v;
    endtask

    task automatic load_expected();
        int depth;
        int addr;
        beat_t bt;
        depth = (sel == 1) ? 16 : 8;
        for (int i = 0; i < depth; i++) begin
            addr    = (sel == 1) ? i : brev3(i);
            bt.idx  = 4'(i);
            bt.data = (sel == 1) ? mem_b[addr] : mem_a[addr];
            bt.last = (i == depth - 1);
            sb_q.push_back(bt);
        end
    endtask

    // mode 0: ready held high, 1: random ready, 2: ready low for 20 cycles, 3: extra start mid-frame.
    task automatic run_frame(input int mode, output int first_v, output int t_last, output int t_done);
        int depth, cyc, dones, beats, extra;
        logic rdy, prev_stall;
        logic [W-1:0] prev_data;
        logic [3:0] prev_idx;
        beat_t exp_b;
        depth = (sel == 1) ? 16 : 8;
        first_v = -1; t_last = -1; t_done = -1;
        dones = 0; beats = 0; extra = -1;
        prev_stall = 1'b0; prev_data = '0; prev_idx = 4'd0;
        load_expected();
        drive_ready(1'b1);
        drive_start(1'b1);
        @(posedge clk); #1;
        drive_start(1'b0);
        cyc = 0;
        while (cyc < 400 && extra != 0) begin
            if (cyc == 0) begin
                checks++;
                if (s_busy !== 1'b1) begin
                    errors++; $display("FAIL busy_after_start got=%b exp=1", s_busy);
                end
            end
            if (s_valid === 1'b1 && first_v < 0) first_v = cyc;
            if (s_done === 1'b1) begin
                dones++; t_done = cyc; extra = 3;
                checks++;
                if (s_busy !== 1'b0) begin
                    errors++; $display("FAIL busy_at_done got=%b exp=0", s_busy);
                end
            end
            if (prev_stall) begin
                checks++;
                if (s_valid !== 1'b1 || s_data !== prev_data || s_index !== prev_idx) begin
                    errors++;
                    $display("FAIL stall_hold got v=%b d=%h i=%0d exp v=1 d=%h i=%0d",
                             s_valid, s_data, s_index, prev_data, prev_idx);
                end
            end
            if (mode == 2 && cyc == 19) begin
                checks++;
                if (s_valid !== 1'b1 || s_addr !== 4'd2) begin
                    errors++;
                    $display("FAIL credit_stop got v=%b addr=%0d exp v=1 addr=2", s_valid, s_addr);
                end
            end
            drive_start((mode == 3 && cyc == 3) ? 1'b1 : 1'b0);
            case (mode)
                1:       rdy = 1'($urandom_range(0, 1));
                2:       rdy = (cyc >= 20);
                default: rdy = 1'b1;
            endcase
            drive_ready(rdy);
            if (s_valid === 1'b1 && rdy) begin
                beats++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++; $display("FAIL extra_beat got i=%0d d=%h exp none", s_index, s_data);
                end else begin
                    exp_b = sb_q.pop_front();
                    if (s_data !== exp_b.data || s_index !== exp_b.idx || s_last !== exp_b.last) begin
                        errors++;
                        $display("FAIL beat got d=%h i=%0d l=%b exp d=%h i=%0d l=%b",
                                 s_data, s_index, s_last, exp_b.data, exp_b.idx, exp_b.last);
                    end
                end
                if (s_last === 1'b1) t_last = cyc;
            end
            prev_stall = (s_valid === 1'b1) && !rdy;
            prev_data  = s_data;
            prev_idx   = s_index;
            if (extra > 0) extra--;
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (dones != 1) begin
            errors++; $display("FAIL done_count got=%0d exp=1", dones);
        end
        checks++;
        if (sb_q.size() != 0 || beats != depth) begin
            errors++; $display("FAIL beat_count got=%0d exp=%0d", beats, depth);
        end
        sb_q.delete();
        drive_start(1'b0);
        drive_ready(1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({a_busy, a_done, a_valid, a_last, a_we, a_addr, a_index, a_data, a_din} !== '0) begin
            errors++;
            $display("FAIL reset_a got busy=%b done=%b v=%b l=%b addr=%0d i=%0d d=%h exp all 0",
                     a_busy, a_done, a_valid, a_last, a_addr, a_index, a_data);
        end
        checks++;
        if ({b_busy, b_done, b_valid, b_last, b_we, b_addr, b_index, b_data, b_din} !== '0) begin
            errors++;
            $display("FAIL reset_b got busy=%b done=%b v=%b l=%b addr=%0d i=%0d d=%h exp all 0",
                     b_busy, b_done, b_valid, b_last, b_addr, b_index, b_data);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_timing(input int s, input int depth);
        int fv, tl, td;
        sel = s;
        run_frame(0, fv, tl, td);
        checks++;
        if (fv != 2 || tl != depth + 1 || td != depth + 2) begin
            errors++;
            $display("FAIL timing_sel%0d got first=%0d last=%0d done=%0d exp 2/%0d/%0d",
                     s, fv, tl, td, depth + 1, depth + 2);
        end
    endtask

    task automatic test_random_ready();
        int fv, tl, td;
        sel = 1;
        run_frame(1, fv, tl, td);
    endtask

    task automatic test_backpressure();
        int fv, tl, td;
        sel = 1;
        run_frame(2, fv, tl, td);
    endtask

    task automatic test_start_ignored();
        int fv, tl, td;
        sel = 0;
        run_frame(3, fv, tl, td);
    endtask

    task automatic test_reset_mid();
        int hs, cyc, bad;
        sel = 0;
        a_ready = 1'b1;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        hs = 0; cyc = 0;
        while (hs < 5 && cyc < 50) begin
            if (a_valid === 1'b1) hs++;
            @(posedge clk); #1;
            cyc++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({a_busy, a_done, a_valid, a_last, a_addr, a_index, a_data} !== '0 || hs != 5) begin
            errors++;
            $display("FAIL mid_reset got hs=%0d busy=%b done=%b v=%b l=%b addr=%0d i=%0d d=%h exp 5 and all 0",
                     hs, a_busy, a_done, a_valid, a_last, a_addr, a_index, a_data);
        end
        rst = 1'b0;
        bad = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (a_done !== 1'b0 || a_valid !== 1'b0 || a_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL quiet_after_reset got=%0d active cycles exp=0", bad);
        end
        test_timing(0, 8);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem_a[i] = W'(i);
        for (int i = 0; i < 16; i++) mem_b[i] = 64'hDEAD_BEEF_0000_0000 + W'(i * 7);
        test_reset();
        test_timing(0, 8);
        test_timing(1, 16);
        test_random_ready();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
